pwm_capture: RTL
================

Name: pwm_capture

Overview:
- Measures an incoming PWM waveform: high time and period, in clk cycles.
- Complements the PWM generator. Used for loopback self-test of generated PWM and for reading external PWM sources such as fan tach and servo feedback.
- Contains a 2-FF synchronizer, an edge detector, a measurement FSM, and stuck-line timeout detection.

Parameters:
CLK_FREQ, 100000000, clk frequency in Hz
MIN_PWM_FREQ, 1000, lowest PWM frequency that must be measured; sets the timeout
WL, $clog2(CLK_FREQ/MIN_PWM_FREQ)+1, width of the counters and result outputs
FILT_LEN, 3, glitch filter stability length in cycles (used only with PWM_CAP_FILTER_EN)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
i_pwm  input  1  asynchronous PWM input
o_high_cnt  output  WL  high time of the last complete period, in cycles
o_period_cnt  output  WL  rise-to-rise period of the last complete period, in cycles
o_valid  output  1  one-cycle strobe; the result outputs were updated this cycle
o_timeout  output  1  sticky; no edge seen within TIMEOUT_CNT cycles
o_level  output  1  current synchronized/filtered input level

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Constants: TIMEOUT_CNT = CLK_FREQ/MIN_PWM_FREQ, which must be < 2**WL.
- Reset: all outputs are 0. Synchronizer flops, counter, and filter are cleared. FSM goes to PRIME. Reset takes priority over everything in every state, including mid-measurement; partial results are discarded.
- Input path: i_pwm passes through a 2-FF synchronizer to give s_pwm, then a previous-sample register.
  - rise_ev = s_pwm & ~prev; fall_ev = ~s_pwm & prev.
  - A rise_ev is flagged 3 cycles after the i_pwm transition.
  - o_level = s_pwm, or the filtered level with the optional feature.
- FSM states: PRIME, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
  - PRIME: lasts 2 cycles. Fills the synchronizer and loads prev with s_pwm, so no edge is reported from reset values. Then moves to WAIT_RISE.
  - WAIT_RISE: cnt increments, saturating. fall_ev is ignored. On rise_ev: cnt<=1, go to MEAS_HIGH.
  - MEAS_HIGH: cnt++. On fall_ev: hold_high<=cnt, go to MEAS_LOW.
  - MEAS_LOW: cnt++. On rise_ev, in the same cycle:
    - o_high_cnt<=hold_high, o_period_cnt<=cnt;
    - o_valid<=1 for one cycle; o_timeout<=0;
    - cnt<=1, stay measuring back-to-back by going to MEAS_HIGH.
- Counter arithmetic: cnt is the number of cycles since the rise event, counted inclusively.
  - Example: rise at cycle 0, fall at cycle 3, rise at cycle 10 gives high=3, period=10.
  - rise_ev and fall_ev are mutually exclusive by construction.
- Timeout: in WAIT_RISE, MEAS_HIGH, or MEAS_LOW, if cnt==TIMEOUT_CNT and no expected edge arrives:
  - o_timeout<=1; o_high_cnt<=0; o_period_cnt<=0; no o_valid;
  - cnt is held; FSM goes to WAIT_RISE.
  - Interpretation: 0% duty gives o_level=0, 100% duty gives o_level=1.
- o_timeout clears only on the next o_valid or on reset.
- After any timeout or reset, the first o_valid requires a full rise→fall→rise sequence. The first high time is never truncated.
- Duty or period changes take effect from the next complete period. There is no averaging.

Optional Feature:
- PWM_CAP_FILTER_EN defined:
  - A stability filter sits between s_pwm and the edge detector.
  - The filtered level changes only after s_pwm has held its new value for FILT_LEN consecutive cycles.
  - Pulses shorter than FILT_LEN cycles are rejected.
  - Edge latency grows by FILT_LEN cycles. Measured counts are unchanged for clean input because both edges are delayed equally.
  - The filter resets to 0 and is primed during PRIME.
- PWM_CAP_FILTER_EN undefined: the filtered level equals s_pwm, and there is no extra logic or latency.

Test Plan:
Test parameters: CLK_FREQ=1000, MIN_PWM_FREQ=50, giving TIMEOUT_CNT=20 and WL=6.
1. Steady PWM, period 10, high 3, after reset → first o_valid after the second rise, then every 10 cycles. o_high_cnt=3, o_period_cnt=10, o_timeout=0.
2. i_pwm held 0 from reset → o_timeout=1 once 20 cycles have counted in WAIT_RISE. Counts 0, o_level=0, no o_valid.
3. Period-10 PWM, then i_pwm stuck 1 → timeout 20 cycles after the last rise. o_level=1, counts 0. Restart period 8, high 5 → o_valid with 5/8, o_timeout cleared.
4. rst pulsed while in MEAS_LOW → all outputs 0 the next cycle. No o_valid until a new rise→fall→rise; the resulting values are exact.
5. Duty stepped from 3/10 to 7/10 → the next complete-period o_valid reports 7/10; no intermediate value.
6. PWM_CAP_FILTER_EN with a 1-cycle low glitch inside the high phase of a 3/10 PWM → reports 3/10, no extra o_valid. Without the define, the same glitch produces a short measurement.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM input capture: measures high time and rise-to-rise period in clk cycles, with stuck-line timeout.
// Optional stability glitch filter enabled by defining PWM_CAP_FILTER_EN.
module pwm_capture #(
    parameter int CLK_FREQ     = 100000000,
    parameter int MIN_PWM_FREQ = 1000,
    parameter int WL           = $clog2(CLK_FREQ/MIN_PWM_FREQ)+1,
    parameter int FILT_LEN     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_pwm,
    output logic [WL-1:0] o_high_cnt,
    output logic [WL-1:0] o_period_cnt,
    output logic          o_valid,
    output logic          o_timeout,
    output logic          o_level
);
    localparam int            TIMEOUT_CNT = CLK_FREQ/MIN_PWM_FREQ;
    localparam logic [WL-1:0] TO_CNT      = WL'(TIMEOUT_CNT);

    typedef enum logic [1:0] {PRIME, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

    state_t        state, state_nx;
    logic          sync1, s_pwm, lvl, prev, prime_done;
    logic          rise_ev, fall_ev;
    logic [WL-1:0] cnt, cnt_nx, cnt_inc, hold_high, hold_nx, high_nx, period_nx;
    logic          valid_nx, timeout_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            s_pwm <= 1'b0;
        end else begin
            sync1 <= i_pwm;
            s_pwm <= sync1;
        end
    end

`ifdef PWM_CAP_FILTER_EN
    localparam int FW = $clog2(FILT_LEN+1);
    logic [FW-1:0] fcnt;

    // Level follows s_pwm only after FILT_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl  <= 1'b0;
            fcnt <= '0;
        end else if (state == PRIME) begin
            lvl  <= sync1;
            fcnt <= '0;
        end else if (s_pwm == lvl) begin
            fcnt <= '0;
        end else if (fcnt == FW'(FILT_LEN-1)) begin
            lvl  <= s_pwm;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end
`else
    assign lvl = s_pwm;
`endif

    // During PRIME prev takes the value lvl is about to get, so no edge appears out of reset.
    always_ff @(posedge clk) begin
        if (rst)                 prev <= 1'b0;
        else if (state == PRIME) prev <= sync1;
        else                     prev <= lvl;
    end

    assign rise_ev = lvl & ~prev;
    assign fall_ev = ~lvl & prev;
    assign o_level = lvl;
    assign cnt_inc = (cnt >= TO_CNT) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= PRIME;
            prime_done   <= 1'b0;
            cnt          <= '0;
            hold_high    <= '0;
            o_high_cnt   <= '0;
            o_period_cnt <= '0;
            o_valid      <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            state        <= state_nx;
            prime_done   <= (state == PRIME);
            cnt          <= cnt_nx;
            hold_high    <= hold_nx;
            o_high_cnt   <= high_nx;
            o_period_cnt <= period_nx;
            o_valid      <= valid_nx;
            o_timeout    <= timeout_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        hold_nx    = hold_high;
        high_nx    = o_high_cnt;
        period_nx  = o_period_cnt;
        valid_nx   = 1'b0;
        timeout_nx = o_timeout;
        case (state)
            PRIME: begin
                if (prime_done) state_nx = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise_ev) begin
                    cnt_nx   = WL'(1);
                    state_nx = MEAS_HIGH;
                end else if (cnt >= TO_CNT) begin
                    timeout_nx = 1'b1;
                    high_nx    = '0;
                    period_nx  = '0;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            MEAS_HIGH: begin
                if (fall_ev) begin
                    hold_nx  = cnt;
                    cnt_nx   = cnt + 1'b1;
                    state_nx = MEAS_LOW;
                end else if (cnt >= TO_CNT) begin
                    timeout_nx = 1'b1;
                    high_nx    = '0;
                    period_nx  = '0;
                    state_nx   = WAIT_RISE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            MEAS_LOW: begin
                // A rise at the timeout boundary still completes the period.
                if (rise_ev) begin
                    high_nx    = hold_high;
                    period_nx  = cnt;
                    valid_nx   = 1'b1;
                    timeout_nx = 1'b0;
                    cnt_nx     = WL'(1);
                    state_nx   = MEAS_HIGH;
                end else if (cnt >= TO_CNT) begin
                    timeout_nx = 1'b1;
                    high_nx    = '0;
                    period_nx  = '0;
                    state_nx   = WAIT_RISE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = PRIME;
        endcase
    end
endmodule
